riscv_execute: RTL

RISCV_EXECUTE -- requirements
Module: riscv_execute

---
 rtl/riscv_execute_pkg.sv | 43 ++++
 rtl/riscv_alu.sv | 39 +++
 rtl/riscv_execute.sv | 128 ++++++++++++
 3 files changed

// File: rtl/riscv_execute_pkg.sv
// Shared definitions for the execute stage.
//   XLEN        datapath width
//   alu_op_e    ALU operation codes driven on i_alu_ctrl_e
//   fwd_sel_e   operand forwarding select codes
//   ex_mem_t    contents of the EX/MEM pipeline register
package riscv_execute_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [3:0] {
      AluAdd   = 4'b0000,
      AluSub   = 4'b0001,
      AluAnd   = 4'b0010,
      AluOr    = 4'b0011,
      AluXor   = 4'b0100,
      AluSlt   = 4'b0101,
      AluSltu  = 4'b0110,
      AluSll   = 4'b0111,
      AluSrl   = 4'b1000,
      AluSra   = 4'b1001,
      AluPassB = 4'b1010
   } alu_op_e;

   typedef enum logic [1:0] {
      FwdReg  = 2'b00,
      FwdWb   = 2'b01,
      FwdMem  = 2'b10,
      FwdReg3 = 2'b11
   } fwd_sel_e;

   typedef struct packed {
      logic            reg_write;
      logic [1:0]      result_src;
      logic            mem_write;
      logic [3:0]      byte_sel;
      logic [2:0]      funct3;
      logic [4:0]      rd;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] write_data;
      logic [XLEN-1:0] pc_plus_4;
   } ex_mem_t;

endpackage

// File: rtl/riscv_alu.sv
// Integer ALU for the execute stage.
//   a, b    operands
//   ctrl    operation (alu_op_e); undefined codes give 0
//   result  operation result, wraps modulo 2^XLEN
//   zero    high when result is all zeros
module riscv_alu
   import riscv_execute_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      ctrl,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   logic [4:0] shamt;
   assign shamt = b[4:0];

   always_comb begin
      result = '0;
      case (ctrl)
         AluAdd:   result = a + b;
         AluSub:   result = a - b;
         AluAnd:   result = a & b;
         AluOr:    result = a | b;
         AluXor:   result = a ^ b;
         AluSlt:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         AluSltu:  result = {{(XLEN-1){1'b0}}, (a < b)};
         AluSll:   result = a << shamt;
         AluSrl:   result = a >> shamt;
         AluSra:   result = $unsigned($signed(a) >>> shamt);
         AluPassB: result = b;
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/riscv_execute.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register.
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_*_e                     ID/EX bundle for the instruction in EX
//   i_forward_a/b_e           operand forwarding selects (fwd_sel_e)
//   i_result_w                writeback-stage result for forwarding
//   i_stall_m, i_flush_m      hold / bubble the EX/MEM register
//   o_pc_src_e, o_pc_target_e combinational fetch redirect
//   o_*_m                     registered M-stage outputs
module riscv_execute
   import riscv_execute_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_reg_write_e,
   input  logic [1:0]      i_result_src_e,
   input  logic            i_mem_write_e,
   input  logic            i_jump_e,
   input  logic            i_branch_e,
   input  logic [3:0]      i_alu_ctrl_e,
   input  logic            i_alu_src_e_a,
   input  logic            i_alu_src_e_b,
   input  logic [XLEN-1:0] i_rd_1e,
   input  logic [XLEN-1:0] i_rd_2e,
   input  logic [XLEN-1:0] i_pc_e,
   input  logic [XLEN-1:0] i_ext_imm_e,
   input  logic [XLEN-1:0] i_pc_plus_4e,
   input  logic [4:0]      i_rd_e,
   input  logic            i_alu_jalr_e,
   input  logic            i_zero_condition_e,
   input  logic [2:0]      i_funct3_e,
   input  logic [3:0]      i_ctrl_mem_byte_sel_e,
   input  logic [1:0]      i_forward_a_e,
   input  logic [1:0]      i_forward_b_e,
   input  logic [XLEN-1:0] i_result_w,
   input  logic            i_stall_m,
   input  logic            i_flush_m,
   output logic            o_pc_src_e,
   output logic [XLEN-1:0] o_pc_target_e,
   output logic            o_reg_write_m,
   output logic [1:0]      o_result_src_m,
   output logic            o_mem_write_m,
   output logic [3:0]      o_ctrl_mem_byte_sel_m,
   output logic [2:0]      o_funct3_m,
   output logic [4:0]      o_rd_m,
   output logic [XLEN-1:0] o_alu_result_m,
   output logic [XLEN-1:0] o_write_data_m,
   output logic [XLEN-1:0] o_pc_plus_4m
);

   logic [XLEN-1:0] fwd_a;
   logic [XLEN-1:0] fwd_b;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;
   ex_mem_t         mem_d;
   ex_mem_t         mem_q;

   // FwdMem reads the registered result, so during a stall it sees the held value.
   always_comb begin
      fwd_a = i_rd_1e;
      case (i_forward_a_e)
         FwdWb:   fwd_a = i_result_w;
         FwdMem:  fwd_a = mem_q.alu_result;
         default: fwd_a = i_rd_1e;
      endcase
   end

   always_comb begin
      fwd_b = i_rd_2e;
      case (i_forward_b_e)
         FwdWb:   fwd_b = i_result_w;
         FwdMem:  fwd_b = mem_q.alu_result;
         default: fwd_b = i_rd_2e;
      endcase
   end

   assign src_a = i_alu_src_e_a ? i_pc_e : fwd_a;
   assign src_b = i_alu_src_e_b ? i_ext_imm_e : fwd_b;

   riscv_alu u_alu (
      .a      (src_a),
      .b      (src_b),
      .ctrl   (i_alu_ctrl_e),
      .result (alu_result),
      .zero   (alu_zero)
   );

   // zero_condition picks BEQ-style (taken on zero) or BNE-style (taken on nonzero).
   assign o_pc_src_e    = i_jump_e | (i_branch_e & (alu_zero == i_zero_condition_e));
   assign o_pc_target_e = i_alu_jalr_e ? {alu_result[XLEN-1:1], 1'b0} : (i_pc_e + i_ext_imm_e);

   always_comb begin
      mem_d            = '0;
      mem_d.reg_write  = i_reg_write_e;
      mem_d.result_src = i_result_src_e;
      mem_d.mem_write  = i_mem_write_e;
      mem_d.byte_sel   = i_ctrl_mem_byte_sel_e;
      mem_d.funct3     = i_funct3_e;
      mem_d.rd         = i_rd_e;
      mem_d.alu_result = alu_result;
      // Store data is the forwarded rs2, never the immediate.
      mem_d.write_data = fwd_b;
      mem_d.pc_plus_4  = i_pc_plus_4e;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mem_q <= '0;
      end else if (i_flush_m) begin
         mem_q <= '0;
      end else if (!i_stall_m) begin
         mem_q <= mem_d;
      end
   end

   assign o_reg_write_m         = mem_q.reg_write;
   assign o_result_src_m        = mem_q.result_src;
   assign o_mem_write_m         = mem_q.mem_write;
   assign o_ctrl_mem_byte_sel_m = mem_q.byte_sel;
   assign o_funct3_m            = mem_q.funct3;
   assign o_rd_m                = mem_q.rd;
   assign o_alu_result_m        = mem_q.alu_result;
   assign o_write_data_m        = mem_q.write_data;
   assign o_pc_plus_4m          = mem_q.pc_plus_4;

endmodule
